rr_arb_mux4: RTL and testbench
==============================

Name: rr_arb_mux4

Overview:
- Round-robin arbiter that shares one W-bit 4:1 mux datapath among four requesters.
- Grants one requester at a time and holds the grant while that requester keeps requesting, up to MAX_HOLD cycles.
- Drives the 2-bit mux select from registered state, so the shared output is glitch-free and owned by exactly one source.
- Sits between four producer ports and a single downstream consumer.

Parameters:
- W, 32, data width of each source and of the output.
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (legal range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request per source; bit i belongs to d[i].
- d0, d1, d2, d3  input  W each  source data.
- gnt  output  4  one-hot grant (all zero when idle), registered.
- sel  output  2  index of the current owner, registered; drives the mux.
- y  output  W  data of the selected source (combinational from sel).
- y_valid  output  1  high while in GRANT (busy), registered.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - gnt=0, sel=0, y_valid=0, state=IDLE, ptr=0, hold_cnt=0.
  - y follows d0 while sel=0.
- State IDLE:
  - If req==0 at a clock edge, stay in IDLE.
  - Otherwise pick the winner: the first set bit of req, searching circularly from ptr.
  - Next edge: state=GRANT, gnt=onehot(winner), sel=winner, y_valid=1, hold_cnt=1.
  - Latency is 1 cycle: req rises in cycle N, gnt is visible in cycle N+1.
- State GRANT, evaluated at each edge with owner = sel:
  - Continue when req[owner]=1 and hold_cnt<MAX_HOLD: hold gnt/sel, hold_cnt+1.
  - Release when req[owner]=0, or when hold_cnt==MAX_HOLD (timeout):
    - Set ptr=(owner+1) mod 4.
    - Re-arbitrate the same edge: search req from the new ptr, with the owner's own bit searched last.
    - If a winner exists: stay in GRANT, load the new gnt/sel, hold_cnt=1. There is no bubble between owners.
    - If no winner: state=IDLE, gnt=0, y_valid=0; sel keeps its last value.
- Timeout with owner still requesting and no other requester: the owner is re-granted with hold_cnt=1, and gnt stays continuously high.
- Requester obligation: gnt remains high in the cycle where the owner drops req (the drop is seen at the next edge). The owner must not present new data in that cycle.
- Invariants:
  - gnt is zero or one-hot at all times.
  - When gnt!=0, gnt == (1<<sel).
  - y_valid == (gnt!=0).
- Reqs on non-owners while in GRANT are ignored until release; there is no preemption.
- hold_cnt is 8 bits and saturates at MAX_HOLD; it never wraps.
- ptr advances only on release, never in IDLE.

Decomposition:
- Package rr_arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - localparam NSRC=4.
  - Function rr_pick(req, ptr, exclude_last): returns found flag and 2-bit index.
- Sub-module: reuse the team's existing mux4 (parameter W), instantiated with sel driving its select, for the y datapath. No new sub-module is needed.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, y_valid=0, sel=0. Assert rst_n=0 mid-grant -> gnt=0 immediately, before the next clock edge.
- req=4'b0100 at cycle 2, held 3 cycles, d2=32'hA5A5_0002 -> gnt=4'b0100 in cycles 3-5, y=32'hA5A5_0002, y_valid=1. req drops, sampled at the next edge -> gnt=0, y_valid=0.
- req=4'b1111 held constant, MAX_HOLD=8, after reset -> owners 0,1,2,3,0,... each for exactly 8 cycles. No idle cycle between owners. gnt is one-hot every cycle.
- Owner 1 holding, req=4'b0010; assert req[3] mid-hold -> owner 1 keeps the grant until MAX_HOLD. Then sel=3 on the very next cycle.
- Only req[2] held for 20 cycles, MAX_HOLD=8 -> gnt stays 4'b0100 throughout, and hold_cnt returns to 1 at cycles 9 and 17.
- Owner 0 drops req while req=4'b1001 -> sel becomes 3, not 0, on the release edge. ptr=1 afterwards.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and the circular priority search for the round-robin arbiter.
// Used by rr_arb_mux4.
package rr_arb_pkg;

    localparam int NSRC = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First set bit of req, searching circularly from ptr.
    // exclude_last drops the slot just before ptr from the search.
    function automatic pick_t rr_pick(
        input logic [NSRC-1:0] req,
        input logic [1:0]      ptr,
        input logic            exclude_last
    );
        pick_t      p;
        logic [1:0] i;
        p = '0;
        // Walk from the far end so the slot closest to ptr wins.
        for (int k = NSRC - 1; k >= 0; k--) begin
            i = ptr + 2'(k);
            if (req[i] && !(exclude_last && (k == NSRC - 1))) begin
                p.found = 1'b1;
                p.idx   = i;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain W-bit 4:1 multiplexer.
// Used by rr_arb_mux4 for the shared output.
module mux4 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_arb_mux4.sv
// Round-robin arbiter owning a shared 4:1 mux; grant is held while the
// owner keeps requesting, up to MAX_HOLD cycles.
module rr_arb_mux4
    import rr_arb_pkg::*;
#(
    parameter int W        = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [W-1:0]    d0,
    input  logic [W-1:0]    d1,
    input  logic [W-1:0]    d2,
    input  logic [W-1:0]    d3,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic [W-1:0]    y,
    output logic            y_valid
);

    localparam logic [7:0] MAX_Q = 8'(MAX_HOLD);

    arb_state_t state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       y_valid_q, y_valid_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] ptr_q, ptr_d;
    pick_t      pick;
    logic [1:0] owner;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        y_valid_d  = y_valid_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        pick       = '0;
        owner      = sel_q;
        unique case (state_q)
            IDLE: begin
                pick = rr_pick(req, ptr_q, 1'b0);
                if (pick.found) begin
                    state_d    = GRANT;
                    gnt_d      = 4'b0001 << pick.idx;
                    sel_d      = pick.idx;
                    y_valid_d  = 1'b1;
                    hold_cnt_d = 8'd1;
                end
            end
            GRANT: begin
                if (req[owner] && (hold_cnt_q < MAX_Q)) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    // Searching from owner+1 puts the owner's bit last.
                    ptr_d = owner + 2'd1;
                    pick  = rr_pick(req, ptr_d, 1'b0);
                    if (pick.found) begin
                        gnt_d      = 4'b0001 << pick.idx;
                        sel_d      = pick.idx;
                        hold_cnt_d = 8'd1;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = 4'b0000;
                        y_valid_d  = 1'b0;
                        hold_cnt_d = 8'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            y_valid_q  <= 1'b0;
            hold_cnt_q <= 8'd0;
            ptr_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            y_valid_q  <= y_valid_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y_valid = y_valid_q;

    mux4 #(.W(W)) u_mux (
        .sel (sel_q),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y   (y)
    );

endmodule

// File: tb/tb_rr_arb_mux4.sv
// Bench for rr_arb_mux4: directed literal cases plus randomized traffic
// checked every cycle against an ownership model.
module tb_rr_arb_mux4;

    localparam int W        = 32;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] y;
    logic         y_valid;

    int n_chk  = 0;
    int n_fail = 0;

    rr_arb_mux4 #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the mux, for how long, and where the search starts.
    int         m_owner;
    int         m_ptr;
    int         m_cnt;
    int         m_sel;

    function automatic int search(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            w = search(req, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_cnt   = 1;
            end
        end else if (req[m_owner] && m_cnt < MAX_HOLD) begin
            m_cnt = m_cnt + 1;
        end else begin
            m_ptr = (m_owner + 1) % 4;
            w     = search(req, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_cnt   = 1;
            end else begin
                m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0]   eg;
        logic [W-1:0] ey;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        case (m_sel)
            0: ey = d0;
            1: ey = d1;
            2: ey = d2;
            default: ey = d3;
        endcase
        check("model_gnt", 64'(gnt), 64'(eg));
        check("model_sel", 64'(sel), 64'(m_sel));
        check("model_valid", 64'(y_valid), 64'(m_owner >= 0));
        check("model_y", 64'(y), 64'(ey));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        d0    = 32'h1111_0000;
        d1    = 32'h2222_0001;
        d2    = 32'h3333_0002;
        d3    = 32'h4444_0003;
        do_reset();

        for (int k = 0; k < 5; k++) begin
            cyc();
            check("idle_gnt", 64'(gnt), 64'h0);
            check("idle_valid", 64'(y_valid), 64'h0);
            check("idle_sel", 64'(sel), 64'h0);
            check("idle_y", 64'(y), 64'h1111_0000);
        end

        d2  = 32'hA5A5_0002;
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("single_gnt", 64'(gnt), 64'h4);
            check("single_y", 64'(y), 64'hA5A5_0002);
            check("single_valid", 64'(y_valid), 64'h1);
        end
        req = 4'b0000;
        cyc();
        check("drop_gnt", 64'(gnt), 64'h0);
        check("drop_valid", 64'(y_valid), 64'h0);

        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            cyc();
            check("rr_sel", 64'(sel), 64'((k / 8) % 4));
            check("rr_gnt", 64'(gnt), 64'(4'b0001 << ((k / 8) % 4)));
        end

        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 9; k++) begin
            cyc();
            if (k == 2) req = 4'b1010;
            check("nopre_sel", 64'(sel), 64'((k < 8) ? 1 : 3));
        end

        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("solo_gnt", 64'(gnt), 64'h4);
            check("solo_hold", 64'(dut.hold_cnt_q), 64'((k % 8) + 1));
        end

        do_reset();
        req = 4'b0001;
        cyc();
        cyc();
        req = 4'b1001;
        cyc();
        check("pass_sel0", 64'(sel), 64'h0);
        req = 4'b1000;
        cyc();
        check("pass_sel3", 64'(sel), 64'h3);
        check("pass_ptr", 64'(dut.ptr_q), 64'h1);

        do_reset();
        req = 4'b0001;
        cyc();
        cyc();
        check("pre_rst_gnt", 64'(gnt), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_gnt", 64'(gnt), 64'h0);
        check("async_valid", 64'(y_valid), 64'h0);
        cyc();
        rst_n = 1'b1;

        do_reset();
        for (int k = 0; k < 3000; k++) begin
            cyc();
            if ($urandom_range(0, 99) < 30) begin
                req = (($urandom_range(0, 99) < 25)) ? 4'b0000
                                                      : 4'($urandom_range(0, 15));
            end
            d0 = $urandom;
            d1 = $urandom;
            d2 = $urandom;
            d3 = $urandom;
        end

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
